mux_receiver: RTL

Receiving end of the time-multiplexed digit bus produced by the display scanner. The bus is a shared value word plus an active-low one-hot select. The block samples the bus and waits until each select has dwelt for a programmable settle time. It then latches the value into a per-digit register, reconstructing the parallel digit array. It also flags completed in-order frames and malformed selects, for display loop-back checking and for chaining clock boards.

---
 rtl/mux_pkg.sv | 38 +++
 rtl/onehot_low_decoder.sv | 42 ++++
 rtl/mux_receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the time-multiplexed digit bus (scanner and receiver):
// default geometry, the blank select code, receiver frame-state encoding and a
// helper that counts low bits of an active-low select word.
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int SEL_QTD_DEF     = 4;
    localparam int SEL_QTD_LOG_DEF = 2;
    localparam int WIDTH_DEF       = 4;
    localparam int SETTLE_DEF      = 2;
    localparam int SETTLE_LOG_DEF  = 2;

    // No digit selected: every active-low select line released.
    localparam logic [SEL_QTD_DEF-1:0] BLANK_SEL = {SEL_QTD_DEF{1'b1}};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    // Number of low bits among the lowest n bits of sel.
    function automatic int unsigned onehot_low_count(input logic [31:0] sel,
                                                     input int unsigned n);
        int unsigned c;
        c = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((i < n) && (sel[i] == 1'b0)) begin
                c = c + 32'd1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/onehot_low_decoder.sv
// -----------------------------------------------------------------------------
// onehot_low_decoder
// Classifies a sampled active-low select word.
// Ports:
//   s_sel     in  SEL_QTD      sampled select, active-low
//   index     out SEL_QTD_LOG  position of the low bit (meaningful when valid)
//   valid     out 1            exactly one bit low
//   blank     out 1            all bits high
//   malformed out 1            two or more bits low
// -----------------------------------------------------------------------------
module onehot_low_decoder
    import mux_pkg::*;
#(
    parameter int SEL_QTD     = SEL_QTD_DEF,
    parameter int SEL_QTD_LOG = SEL_QTD_LOG_DEF
) (
    input  logic [SEL_QTD-1:0]     s_sel,
    output logic [SEL_QTD_LOG-1:0] index,
    output logic                   valid,
    output logic                   blank,
    output logic                   malformed
);

    int unsigned lows;

    // Count low lines and locate the (single) low bit.
    always_comb begin
        lows  = onehot_low_count(32'(s_sel), SEL_QTD);
        index = '0;
        for (int i = 0; i < SEL_QTD; i++) begin
            if (s_sel[i] == 1'b0) begin
                index = SEL_QTD_LOG'(i);
            end else begin
                index = index;
            end
        end
        valid     = (lows == 32'd1);
        blank     = (lows == 32'd0);
        malformed = (lows > 32'd1);
    end

endmodule

// File: rtl/mux_receiver.sv
// -----------------------------------------------------------------------------
// mux_receiver
// Rebuilds the parallel digit array from the time-multiplexed digit bus. The
// bus is sampled every cycle; once a valid select has been stable for SETTLE
// sampled cycles its value is latched into that digit's register. In-order
// frames 0..SEL_QTD-1 raise a one-cycle frame_done; malformed selects set the
// sticky sel_err.
// Ports:
//   clk        in  1                  clock, all state on posedge
//   _rst       in  1                  synchronous active-low reset
//   in_value   in  WIDTH              multiplexed digit value
//   in_sel     in  SEL_QTD            active-low one-hot select, all-ones = blank
//   out_values out [SEL_QTD][WIDTH]   captured digit array
//   out_valid  out SEL_QTD            digit captured since reset
//   frame_done out 1                  pulse after an in-order frame completes
//   sel_err    out 1                  sticky malformed-select flag
// Build option: MUX_RX_DEGLITCH_VALUE_EN also requires the sampled value to be
// stable for the settle counter to advance.
// -----------------------------------------------------------------------------
module mux_receiver
    import mux_pkg::*;
#(
    parameter int SEL_QTD     = SEL_QTD_DEF,
    parameter int SEL_QTD_LOG = SEL_QTD_LOG_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int SETTLE_LOG  = SETTLE_LOG_DEF
) (
    input  logic                            clk,
    input  logic                            _rst,
    input  logic [WIDTH-1:0]                in_value,
    input  logic [SEL_QTD-1:0]              in_sel,
    output logic [SEL_QTD-1:0][WIDTH-1:0]   out_values,
    output logic [SEL_QTD-1:0]              out_valid,
    output logic                            frame_done,
    output logic                            sel_err
);

    logic [SEL_QTD-1:0]     s_sel;
    logic [SEL_QTD-1:0]     prev_sel;
    logic [WIDTH-1:0]       s_value;
`ifdef MUX_RX_DEGLITCH_VALUE_EN
    logic [WIDTH-1:0]       prev_value;
`endif
    logic [SETTLE_LOG-1:0]  cnt;
    logic [SETTLE_LOG-1:0]  cnt_next;
    logic                   captured;
    logic                   captured_eff;
    logic                   sel_new;
    logic                   stable;
    logic                   capture;

    logic [SEL_QTD_LOG-1:0] dec_index;
    logic                   dec_valid;
    logic                   dec_blank;
    logic                   dec_malformed;

    rx_state_t              state;
    logic [SEL_QTD_LOG-1:0] exp_idx;
    logic                   frame_pend;

    onehot_low_decoder #(
        .SEL_QTD     (SEL_QTD),
        .SEL_QTD_LOG (SEL_QTD_LOG)
    ) u_decoder (
        .s_sel     (s_sel),
        .index     (dec_index),
        .valid     (dec_valid),
        .blank     (dec_blank),
        .malformed (dec_malformed)
    );

    // Settle-counter update and capture decision for the current sample.
    always_comb begin
        sel_new = (s_sel != prev_sel);
`ifdef MUX_RX_DEGLITCH_VALUE_EN
        stable  = !sel_new && (s_value == prev_value);
`else
        stable  = !sel_new;
`endif
        cnt_next = cnt;
        if (dec_valid) begin
            if (!stable) begin
                cnt_next = SETTLE_LOG'(1);
            end else if (cnt < SETTLE_LOG'(SETTLE)) begin
                cnt_next = cnt + 1'b1;
            end else begin
                cnt_next = cnt;
            end
        end else if (dec_blank) begin
            cnt_next = '0;
        end else begin
            cnt_next = '0;
        end
        // A value restart inside one select dwell must not cause a rewrite,
        // so the "already captured" mark survives until the select changes.
        captured_eff = captured && !sel_new;
        capture      = dec_valid && (cnt_next == SETTLE_LOG'(SETTLE)) && !captured_eff;
    end

    // Bus sampling, settle counter, digit registers and error flag.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            s_sel      <= {SEL_QTD{1'b1}};
            prev_sel   <= {SEL_QTD{1'b1}};
            s_value    <= '0;
`ifdef MUX_RX_DEGLITCH_VALUE_EN
            prev_value <= '0;
`endif
            cnt        <= '0;
            captured   <= 1'b0;
            out_values <= '0;
            out_valid  <= '0;
            sel_err    <= 1'b0;
        end else begin
            s_sel      <= in_sel;
            prev_sel   <= s_sel;
            s_value    <= in_value;
`ifdef MUX_RX_DEGLITCH_VALUE_EN
            prev_value <= s_value;
`endif
            cnt        <= cnt_next;
            captured   <= dec_valid ? (capture || captured_eff) : 1'b0;
            if (capture) begin
                out_values[dec_index] <= s_value;
                out_valid[dec_index]  <= 1'b1;
            end else begin
                out_values <= out_values;
                out_valid  <= out_valid;
            end
            sel_err <= sel_err || dec_malformed;
        end
    end

    // Frame tracker; frame_done follows the final capture by one edge.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            state      <= IDLE;
            exp_idx    <= '0;
            frame_pend <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_pend;
            frame_pend <= 1'b0;
            if (dec_malformed) begin
                state <= IDLE;
            end else if (capture) begin
                case (state)
                    IDLE: begin
                        if (dec_index == '0) begin
                            state   <= COLLECT;
                            exp_idx <= SEL_QTD_LOG'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    COLLECT: begin
                        if (dec_index == exp_idx) begin
                            if (exp_idx == SEL_QTD_LOG'(SEL_QTD - 1)) begin
                                frame_pend <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                exp_idx <= exp_idx + 1'b1;
                            end
                        end else if (dec_index == '0) begin
                            exp_idx <= SEL_QTD_LOG'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                state <= state;
            end
        end
    end

endmodule
